// File: rtl/tank_level_ctrl.sv
// rtl/tank_level_ctrl.sv - hysteresis fill/consume supervisor for the tank level block
// Registered FSM: IDLE/FILLING/SERVING/FAULT with stall detection and a saturating refill counter.
module tank_level_ctrl #(
   parameter logic [7:0] LOW_MARK    = 8'd32,
   parameter logic [7:0] HIGH_MARK   = 8'd200,
   parameter int         STALL_LIMIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] height,
   input  logic       error,
   input  logic       demand,
   input  logic       clear,
   output logic       fill,
   output logic       consume,
   output logic       alarm,
   output logic [2:0] state,
   output logic [7:0] refill_count
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FILLING = 3'd1,
      S_SERVING = 3'd2,
      S_FAULT   = 3'd3
   } state_t;

   localparam logic [7:0] STALL_LIM8 = 8'(STALL_LIMIT);

   state_t     r_state;
   logic [7:0] r_stall;
   logic [7:0] r_prev;
   logic [7:0] r_count;

   state_t     w_next;
   logic [7:0] w_stall_next;
   logic [7:0] w_stall_inc;
   logic       w_refill_done;

   always_comb begin
      w_next        = r_state;
      w_stall_next  = 8'd0;
      w_refill_done = 1'b0;
      w_stall_inc   = (height <= r_prev) ? (r_stall + 8'd1) : 8'd0;
      case (r_state)
         S_IDLE: begin
            if (error)                              w_next = S_FAULT;
            else if (height < LOW_MARK)             w_next = S_FILLING;
            else if (demand && (height != 8'd0))    w_next = S_SERVING;
         end
         S_FILLING: begin
            // High mark beats the stall limit when both land on the same edge.
            if (error) begin
               w_next = S_FAULT;
            end else if (height >= HIGH_MARK) begin
               w_next        = S_IDLE;
               w_refill_done = 1'b1;
            end else if (w_stall_inc >= STALL_LIM8) begin
               w_next = S_FAULT;
            end else begin
               w_stall_next = w_stall_inc;
            end
         end
         S_SERVING: begin
            if (error)                   w_next = S_FAULT;
            else if (height < LOW_MARK)  w_next = S_FILLING;
            else if (!demand)            w_next = S_IDLE;
         end
         S_FAULT: begin
            if (clear && !error)         w_next = S_IDLE;
         end
         default:                        w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_stall <= 8'd0;
         r_prev  <= 8'd0;
         r_count <= 8'd0;
         fill    <= 1'b0;
         consume <= 1'b0;
         alarm   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_stall <= w_stall_next;
         r_prev  <= height;
         if (w_refill_done && (r_count != 8'hFF))
            r_count <= r_count + 8'd1;
         fill    <= (w_next == S_FILLING);
         consume <= (w_next == S_SERVING);
         alarm   <= (w_next == S_FAULT);
      end
   end

   assign state        = r_state;
   assign refill_count = r_count;

endmodule
